// File: rtl/sram_a_pkg.sv
// Shared widths, word type and reset-pattern helper for the sram_a scratch RAM.
// The optional output register is enabled by the SRAM_A_OUTREG_EN macro (see sram_a.sv).
package sram_a_pkg;

  localparam int unsigned SRAM_A_ADDR_W_DEF = 8;
  localparam int unsigned SRAM_A_DATA_W_DEF = 8;

  typedef logic [SRAM_A_DATA_W_DEF-1:0] sram_a_word_t;

  // Reset pattern: each word holds its own address modulo 2**data_w.
  function automatic int unsigned init_word(input int unsigned addr,
                                            input int unsigned data_w);
    if (data_w >= 32) begin
      return addr;
    end
    return addr & ((32'd1 << data_w) - 32'd1);
  endfunction

endpackage

// File: rtl/sram_a_outreg.sv
// Optional read-data register for sram_a: one cycle of latency, async clear.
// Only instantiated when SRAM_A_OUTREG_EN is defined.
module sram_a_outreg
  import sram_a_pkg::*;
#(
  parameter int unsigned DATA_W = SRAM_A_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sram_a.sv
// Single-port DEPTH x DATA_W scratch RAM: asynchronous read, synchronous write,
// reset preloads mem[i] = i. Define SRAM_A_OUTREG_EN for a registered read port.
module sram_a
  import sram_a_pkg::*;
#(
  parameter int unsigned ADDR_W = SRAM_A_ADDR_W_DEF,
  parameter int unsigned DATA_W = SRAM_A_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Dir,
  input  logic [DATA_W-1:0] Dato_e,
  input  logic              We,
  input  logic              En,
  output logic [DATA_W-1:0] Dato_s
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] w_rd;

  // Reset preloads the address pattern; reset overrides any write on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= DATA_W'(init_word(i, DATA_W));
      end
    end else if (En && We) begin
      r_mem[Dir] <= Dato_e;
    end
  end

  // Read port shows the stored word even during a write cycle; no Dato_e bypass.
  assign w_rd = En ? r_mem[Dir] : '0;

`ifdef SRAM_A_OUTREG_EN
  sram_a_outreg #(
    .DATA_W (DATA_W)
  ) u_outreg (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_rd),
    .o_q   (Dato_s)
  );
`else
  assign Dato_s = w_rd;
`endif

  a_dir_known: assert property (@(posedge clk) disable iff (!rst_n)
                                (En |-> !$isunknown(Dir)))
    else $warning("sram_a: Dir is unknown while En=1");

endmodule

// File: tb/tb_sram_a.sv
// Self-checking bench for sram_a (default build: combinational read port).
module tb_sram_a;
  import sram_a_pkg::*;

  localparam int unsigned AW = SRAM_A_ADDR_W_DEF;
  localparam int unsigned DW = SRAM_A_DATA_W_DEF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] Dir;
  sram_a_word_t  Dato_e;
  logic          We;
  logic          En;
  sram_a_word_t  Dato_s;

  always #5 clk = ~clk;

  sram_a #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Dir    (Dir),
    .Dato_e (Dato_e),
    .We     (We),
    .En     (En),
    .Dato_s (Dato_s)
  );

  typedef struct {
    string         name;
    logic          en;
    logic          we;
    logic [AW-1:0] dir;
    sram_a_word_t  din;
    bit            clocked;
    sram_a_word_t  exp;
  } vec_t;

  typedef struct {
    string        name;
    sram_a_word_t exp;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Drive inputs and queue the value Dato_s must show once they take effect.
  task automatic drive(input logic en, input logic we, input logic [AW-1:0] dir,
                       input sram_a_word_t din, input string name,
                       input sram_a_word_t exp);
    sb_t e;
    En = en; We = we; Dir = dir; Dato_e = din;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d required an expectation", Dato_s);
      return;
    end
    e = sb_q.pop_front();
    if (Dato_s !== e.exp) begin
      errors++;
      $display("FAIL %s: Dato_s=%0d required %0d", e.name, Dato_s, e.exp);
    end
  endtask

  task automatic settle_check();
    #1;
    check_out();
  endtask

  task automatic edge_check();
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    vec_t v;

    // Vector table: write burst, readback, untouched word, disabled write.
    for (int k = 0; k < 12; k++) begin
      v.name = $sformatf("wr_burst_%0d", k);
      v.en = 1'b1; v.we = 1'b1; v.dir = AW'(k); v.din = DW'(200 + k);
      v.clocked = 1'b1; v.exp = DW'(200 + k);
      vecs.push_back(v);
    end
    for (int k = 0; k < 12; k++) begin
      v.name = $sformatf("readback_%0d", k);
      v.en = 1'b1; v.we = 1'b0; v.dir = AW'(k); v.din = 8'h00;
      v.clocked = 1'b0; v.exp = DW'(200 + k);
      vecs.push_back(v);
    end
    v.name = "untouched_12";
    v.en = 1'b1; v.we = 1'b0; v.dir = 8'd12; v.din = 8'h00; v.clocked = 1'b0; v.exp = 8'd12;
    vecs.push_back(v);
    v.name = "disabled_write";
    v.en = 1'b0; v.we = 1'b1; v.dir = 8'd3; v.din = 8'h55; v.clocked = 1'b1; v.exp = 8'd0;
    vecs.push_back(v);
    v.name = "disabled_no_store";
    v.en = 1'b1; v.we = 1'b0; v.dir = 8'd3; v.din = 8'h00; v.clocked = 1'b0; v.exp = 8'd203;
    vecs.push_back(v);

    // Reset state: pattern visible with En=1, zero with En=0, no clock needed.
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'd9, 8'h00, "rst_en0", 8'd0);
    settle_check();
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 1'b0, AW'(k), 8'h00, $sformatf("rst_read_%0d", k), DW'(k));
      settle_check();
      #9;
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 256; k++) begin
      drive(1'b1, 1'b0, AW'(k), 8'h00, $sformatf("sweep_%0d", k), DW'(k));
      settle_check();
    end

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].en, vecs[i].we, vecs[i].dir, vecs[i].din, vecs[i].name, vecs[i].exp);
      if (vecs[i].clocked) edge_check();
      else settle_check();
    end

    // Write cycle: old word before the edge (no Dato_e bypass), new word after.
    @(negedge clk);
    drive(1'b1, 1'b1, 8'd20, 8'h99, "wr_pre_edge", 8'd20);
    settle_check();
    sb_q.push_back('{name: "wr_post_edge", exp: 8'h99});
    edge_check();
    @(negedge clk);
    drive(1'b1, 1'b0, 8'd21, 8'h00, "neighbour_21", 8'd21);
    settle_check();
    drive(1'b1, 1'b0, 8'd19, 8'h00, "neighbour_19", 8'd19);
    settle_check();
    drive(1'b1, 1'b0, 8'd20, 8'h00, "dir_change_20", 8'h99);
    settle_check();
    drive(1'b0, 1'b0, 8'd20, 8'h00, "en0_read", 8'd0);
    settle_check();
    drive(1'b1, 1'b0, 8'd255, 8'h00, "top_addr", 8'd255);
    settle_check();

    // Async reset between edges: pattern returns at once; a write during reset is dropped.
    @(negedge clk);
    #2;
    drive(1'b1, 1'b0, 8'd5, 8'h00, "rst_async_5", 8'd5);
    rst_n = 1'b0;
    settle_check();
    drive(1'b1, 1'b1, 8'd6, 8'hAA, "rst_write_ignored", 8'd6);
    edge_check();
    drive(1'b1, 1'b0, 8'd20, 8'h00, "rst_clears_20", 8'd20);
    settle_check();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'd6, 8'h00, "post_rst_6", 8'd6);
    settle_check();
    drive(1'b1, 1'b0, 8'd0, 8'h00, "post_rst_0", 8'd0);
    settle_check();

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries required 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
